// File: rtl/param_readback_tx.sv
`default_nettype none
// ============================================================================
//  Module   : param_readback_tx
//  Purpose  : Snapshots the live pulse-parameter registers on request and
//             sends them to the host as one framed UART 8N1 packet:
//             header byte, 24 payload bytes (MSB byte first), 8-bit checksum.
//  Revision : 1.0  initial release
// ============================================================================
module param_readback_tx #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [15:0] p1wid2,
  input  logic [15:0] del2,
  input  logic [15:0] p2wid2,
  input  logic [15:0] p1st2,
  input  logic [15:0] nut_d,
  input  logic [7:0]  nut_w,
  input  logic [6:0]  pr_att,
  input  logic [7:0]  p_bl,
  input  logic        cp,
  input  logic        bl,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int                  c_BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST    = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]          c_LAST_PAYLOAD = 5'd24;
  localparam logic [4:0]          c_LAST_BYTE    = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [4:0]          r_byte_idx;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_byte;
  logic [7:0]          r_csum;
  logic [191:0]        r_shadow;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  // Payload image in transmit order; the first byte to go out sits in the top bits.
  logic [191:0] w_snapshot;
  logic         w_baud_end;
  logic [2:0]   w_bit_next;
  logic [7:0]   w_next_payload;

  assign w_snapshot     = {per, p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2,
                           nut_d, nut_w, 1'b0, pr_att, p_bl, 6'b0, cp, bl};
  assign w_baud_end     = (r_baud == c_BAUD_LAST);
  assign w_bit_next     = r_bit_idx + 3'd1;
  assign w_next_payload = r_shadow[191:184];

  // Packet sequencer: snapshot, serialise bytes back to back, accumulate checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_byte     <= '0;
      r_csum     <= '0;
      r_shadow   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (send) begin
            r_shadow   <= w_snapshot;
            r_byte     <= HEADER;
            r_csum     <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= w_bit_next;
              r_tx      <= r_byte[w_bit_next];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte_idx == c_LAST_BYTE) begin
              // Busy drops on this edge, so a send seen here is not accepted.
              r_byte_idx <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 5'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
              if (r_byte_idx == c_LAST_PAYLOAD) begin
                // All 24 payload bytes were summed as they were loaded.
                r_byte <= r_csum;
              end else begin
                r_byte   <= w_next_payload;
                r_shadow <= {r_shadow[183:0], 8'h00};
                r_csum   <= r_csum + w_next_payload;
              end
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_readback_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_readback_tx
//  Purpose  : Self-checking bench for param_readback_tx. Expected packets are
//             built from the field values by plain arithmetic and compared
//             against the serial line cycle by cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_readback_tx;

  localparam int         CPB = 16;
  localparam int         LEN = 26 * 10 * CPB;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d;
  logic [7:0]  nut_w;
  logic [6:0]  pr_att;
  logic [7:0]  p_bl;
  logic        cp, bl;
  logic        tx, busy, done;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_q[$];

  param_readback_tx #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .send(send),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .p1wid2(p1wid2), .del2(del2), .p2wid2(p2wid2), .p1st2(p1st2),
    .nut_d(nut_d), .nut_w(nut_w), .pr_att(pr_att), .p_bl(p_bl),
    .cp(cp), .bl(bl),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_field(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(8'(v >> (8 * i)));
  endfunction

  // Packet image from the current field values: header, fields MSB first, sum.
  function automatic void build_expected();
    int sum;
    exp_q.delete();
    exp_q.push_back(HDR);
    push_field(per, 4);
    push_field({16'h0, p1wid}, 2);
    push_field({16'h0, del}, 2);
    push_field({16'h0, p2wid}, 2);
    push_field({16'h0, p1wid2}, 2);
    push_field({16'h0, del2}, 2);
    push_field({16'h0, p2wid2}, 2);
    push_field({16'h0, p1st2}, 2);
    push_field({16'h0, nut_d}, 2);
    push_field({24'h0, nut_w}, 1);
    push_field({25'h0, pr_att}, 1);
    push_field({24'h0, p_bl}, 1);
    push_field({30'h0, cp, bl}, 1);
    sum = 0;
    for (int i = 1; i <= 24; i++) sum += int'(exp_q[i]);
    exp_q.push_back(8'(sum % 256));
  endfunction

  task automatic set_all(input logic [31:0] v);
    per = v; p1wid = v[15:0]; del = v[15:0]; p2wid = v[15:0];
    p1wid2 = v[15:0]; del2 = v[15:0]; p2wid2 = v[15:0]; p1st2 = v[15:0];
    nut_d = v[15:0]; nut_w = v[7:0]; pr_att = v[6:0]; p_bl = v[7:0];
    cp = v[0]; bl = v[0];
  endtask

  task automatic randomize_fields();
    per = $urandom; p1wid = 16'($urandom); del = 16'($urandom);
    p2wid = 16'($urandom); p1wid2 = 16'($urandom); del2 = 16'($urandom);
    p2wid2 = 16'($urandom); p1st2 = 16'($urandom); nut_d = 16'($urandom);
    nut_w = 8'($urandom); pr_att = 7'($urandom); p_bl = 8'($urandom);
    cp = 1'($urandom); bl = 1'($urandom);
  endtask

  // Raise send on a falling edge; the next rising edge accepts the packet.
  task automatic start_pkt();
    @(negedge clk);
    build_expected();
    send = 1'b1;
  endtask

  // Follow one packet on the line. k counts falling edges after acceptance.
  task automatic pkt_body(input string name, input bit hold, input int change_at,
                          input int resend_at, input int reset_at);
    int         line_err, busy_err, b, bi, pos, ph;
    logic       exp_lvl;
    logic [7:0] byte_v, rx;
    bit         aborted;
    line_err = 0; busy_err = 0; aborted = 0; rx = '0;
    for (int k = 0; k <= LEN; k++) begin
      @(negedge clk);
      if (k == LEN) begin
        check_eq({name, "_busy_end"}, {31'h0, busy}, 32'h0);
        check_eq({name, "_done_end"}, {31'h0, done}, 32'h1);
        check_eq({name, "_tx_end"}, {31'h0, tx}, 32'h1);
      end else begin
        b   = k / CPB;
        bi  = b / 10;
        pos = b % 10;
        ph  = k % CPB;
        byte_v  = exp_q[bi];
        exp_lvl = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : byte_v[pos-1];
        if (tx !== exp_lvl) line_err++;
        if (busy !== 1'b1) busy_err++;
        if (done !== 1'b0) busy_err++;
        if (ph == CPB / 2 && pos >= 1 && pos <= 8) rx[pos-1] = tx;
        if (ph == CPB - 1 && pos == 9)
          check_eq($sformatf("%s_byte%0d", name, bi), {24'h0, rx}, {24'h0, exp_q[bi]});
      end
      if (k == 0) send = hold;
      if (k == change_at) randomize_fields();
      if (k == resend_at) send = 1'b1;
      if (k == resend_at + 1) send = hold;
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq({name, "_rst_tx"}, {31'h0, tx}, 32'h1);
        check_eq({name, "_rst_busy"}, {31'h0, busy}, 32'h0);
        reset = 1'b0;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      check_eq({name, "_line_timing"}, line_err, 0);
      check_eq({name, "_busy_window"}, busy_err, 0);
    end
  endtask

  task automatic idle_check(input string name, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    check_eq(name, errs, 0);
  endtask

  initial begin
    reset = 1'b1;
    send  = 1'b0;
    set_all(32'h0);
    repeat (3) @(negedge clk);
    check_eq("reset_tx", {31'h0, tx}, 32'h1);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    check_eq("reset_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    idle_check("idle_after_reset", 5);

    // Single nonzero field: checksum is just the sum of the period bytes.
    set_all(32'h0);
    per = 32'h01020304;
    start_pkt();
    pkt_body("t1", 1'b0, -1, -1, -1);
    idle_check("t1_idle", 5);

    // All ones: exercises the padded pr_att and flag bytes and checksum wrap.
    set_all(32'hFFFF_FFFF);
    start_pkt();
    pkt_body("t2", 1'b0, -1, -1, -1);

    // Inputs change during the packet; the snapshot must be what goes out.
    randomize_fields();
    start_pkt();
    pkt_body("t3", 1'b0, 10, -1, -1);

    // A request while busy is dropped; the line stays idle afterwards.
    randomize_fields();
    start_pkt();
    pkt_body("t4", 1'b0, -1, 1500, -1);
    idle_check("t4_no_second_pkt", 100);

    // Reset mid-packet aborts; the next request yields a full packet.
    randomize_fields();
    start_pkt();
    pkt_body("t5a", 1'b0, -1, -1, 3000);
    idle_check("t5_idle", 20);
    randomize_fields();
    start_pkt();
    pkt_body("t5b", 1'b0, -1, -1, -1);

    // send held high: packets repeat with exactly one idle cycle between them.
    randomize_fields();
    start_pkt();
    pkt_body("t6a", 1'b1, -1, -1, -1);
    pkt_body("t6b", 1'b1, -1, -1, -1);
    pkt_body("t6c", 1'b1, -1, -1, -1);
    send = 1'b0;
    idle_check("t6_idle", 20);

    // Random field sets.
    for (int r = 0; r < 3; r++) begin
      randomize_fields();
      start_pkt();
      pkt_body($sformatf("rnd%0d", r), 1'b0, -1, -1, -1);
      idle_check($sformatf("rnd%0d_idle", r), 3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
